rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port arbiter and sequencer for the register file. Shares the single register-file write port between `NUM_REQ` writeback sources (e.g. ALU, load unit, CSR unit) using round-robin arbitration with a valid/ready handshake. Drives a registered write command into the register file and suppresses writes to register 0. It also keeps a saturating contention counter for performance debug.

## Interface
- `NUM_REQ`, 3, number of writeback requesters (2..8)
- `WIDTH_ADDR`, 5, register address width
- `WIDTH_DATA`, 32, register data width
- `CNT_WIDTH`, 16, contention counter width

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester write request
- `req_ready`  out  NUM_REQ  per-requester grant (one-hot or zero), combinational
- `req_addr`  in  NUM_REQ*WIDTH_ADDR  flattened destination addresses; requester i at bits [i*WIDTH_ADDR +: WIDTH_ADDR]
- `req_data`  in  NUM_REQ*WIDTH_DATA  flattened write data, same packing
- `wr_en`  out  1  register-file write enable (registered)
- `wr_addr`  out  WIDTH_ADDR  register-file write address (registered)
- `wr_data`  out  WIDTH_DATA  register-file write data (registered)
- `grant_id`  out  $clog2(NUM_REQ)  index of requester whose write is on `wr_*` (registered)
- `contention_cnt`  out  CNT_WIDTH  cycles with more than one `req_valid` high, saturating
- `cnt_clear`  in  1  synchronous clear of `contention_cnt`

## Operation
- Round-robin pointer `rr_ptr` marks the highest-priority requester.
- Each cycle the grant goes to the first valid requester at or after `rr_ptr`, searching upward with modulo-`NUM_REQ` wrap.
- `req_ready[i]` = 1 only for the granted requester; all zero when no `req_valid` is high.
- Transfer occurs when `req_valid[i] && req_ready[i]`. At most one transfer per cycle, so the port never stalls when any request is present.
- On a transfer from requester g:
  - `rr_ptr` <= (g+1) mod NUM_REQ.
  - `wr_addr`/`wr_data` <= requester g's fields.
  - `grant_id` <= g.
  - `wr_en` <= 1 unless the address is 0.
- Address 0 write: accepted (ready asserted, pointer advances, `wr_addr`/`wr_data`/`grant_id` still load), but `wr_en` <= 0.
- No transfer in a cycle: `wr_en` <= 0. `wr_addr`, `wr_data` and `grant_id` hold their values.
- Requesters hold `req_valid`, address and data stable until accepted. The arbiter does not buffer unaccepted requests.
- `contention_cnt` increments by 1 in any cycle where popcount(`req_valid`) >= 2, saturating at all-ones.
- `cnt_clear` takes priority over the increment: the counter goes to 0 that cycle.

## Timing
- Reset (`rst_n`=0 at a rising edge) sets:
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0, `grant_id`=0
  - `rr_ptr`=0
  - `contention_cnt`=0
- During reset `req_ready` is forced to all zero, so no transfer is accepted.
- Reset asserted mid-stream discards the in-flight command: `wr_en` is 0 the cycle after the reset edge.
- Latency: a transfer in cycle N gives `wr_en`/`wr_addr`/`wr_data` valid in cycle N+1. The register file commits at the edge ending cycle N+1.
- Throughput: one write per cycle. Back-to-back transfers from different requesters produce consecutive `wr_en` cycles.
- A single requester alone: granted every cycle regardless of `rr_ptr`.
- Pointer wrap: grant to `NUM_REQ-1` sets `rr_ptr` to 0.
- `req_ready` depends combinationally on `req_valid` and `rr_ptr` only, not on `req_addr` or `req_data`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with all `req_valid`=1. Required: `req_ready`=000, `wr_en`=0, `contention_cnt`=0. After release, requester 0 is granted first.
- Single requester: `req_valid`=010, addr 5, data 0xDEADBEEF. Required: `req_ready`=010 the same cycle; next cycle `wr_en`=1, `wr_addr`=5, `wr_data`=0xDEADBEEF, `grant_id`=1.
- Full contention: `req_valid`=111 held 6 cycles. Required: grant order 0,1,2,0,1,2; `wr_en` high 6 consecutive cycles; `contention_cnt`=6.
- x0 suppression: requester 2 writes addr 0, data 0x12345678. Required: accepted; next cycle `wr_en`=0, `grant_id`=2; `rr_ptr` advances to 0.
- Counter saturation/clear: with `CNT_WIDTH`=4, hold 2 requesters valid for 20 cycles. Required: counter stops at 15. Then `cnt_clear`=1 with `req_valid`=011. Required: counter reads 0 the next cycle.
- Reset mid-stream: `req_valid`=111; assert `rst_n`=0 for 1 cycle after the second grant. Required: `wr_en`=0 the following cycle, and the first grant after release is requester 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Round-robin arbiter that shares the single register-file write port
//   between NUM_REQ writeback sources. The winning request is registered
//   onto the wr_* command bus one cycle later. Writes to register 0 are
//   accepted but never enabled. A saturating counter records cycles in
//   which two or more sources requested at the same time.
//
// Ports
//   i_clk             clock, all state updates on the rising edge
//   i_rst_n           synchronous active-low reset
//   i_req_valid       per-requester write request
//   o_req_ready       per-requester grant (one-hot or zero), combinational
//   i_req_addr        flattened addresses, requester i at [i*WIDTH_ADDR +: WIDTH_ADDR]
//   i_req_data        flattened data, same packing
//   o_wr_en           register-file write enable (registered)
//   o_wr_addr         register-file write address (registered)
//   o_wr_data         register-file write data (registered)
//   o_grant_id        requester index of the command on wr_* (registered)
//   o_contention_cnt  saturating count of cycles with >= 2 requests
//   i_cnt_clear       synchronous clear of o_contention_cnt
module rf_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int WIDTH_ADDR = 5,
  parameter int WIDTH_DATA = 32,
  parameter int CNT_WIDTH  = 16,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*WIDTH_ADDR-1:0] i_req_addr,
  input  logic [NUM_REQ*WIDTH_DATA-1:0] i_req_data,
  output logic                          o_wr_en,
  output logic [WIDTH_ADDR-1:0]         o_wr_addr,
  output logic [WIDTH_DATA-1:0]         o_wr_data,
  output logic [ID_W-1:0]               o_grant_id,
  output logic [CNT_WIDTH-1:0]          o_contention_cnt,
  input  logic                          i_cnt_clear
);

  logic [ID_W-1:0]       r_rr_ptr;
  logic                  r_wr_en;
  logic [WIDTH_ADDR-1:0] r_wr_addr;
  logic [WIDTH_DATA-1:0] r_wr_data;
  logic [ID_W-1:0]       r_grant_id;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_found;
  logic [ID_W-1:0]       w_grant_idx;
  logic [NUM_REQ-1:0]    w_grant_oh;
  logic [WIDTH_ADDR-1:0] w_sel_addr;
  logic [WIDTH_DATA-1:0] w_sel_data;
  logic                  w_contend;
  int                    w_idx;

  // Search upward from the pointer with modulo wrap; the first valid
  // requester found wins. Only req_valid and the pointer steer the grant.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_grant_oh  = '0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    w_idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && i_req_valid[w_idx]) begin
        w_found            = 1'b1;
        w_grant_idx        = ID_W'(w_idx);
        w_grant_oh[w_idx]  = 1'b1;
        w_sel_addr         = i_req_addr[w_idx*WIDTH_ADDR +: WIDTH_ADDR];
        w_sel_data         = i_req_data[w_idx*WIDTH_DATA +: WIDTH_DATA];
      end
    end
  end

  // Grants are masked while reset is held so nothing is accepted.
  assign o_req_ready = i_rst_n ? w_grant_oh : '0;
  assign w_contend   = ($countones(i_req_valid) >= 2);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr_ptr   <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_grant_id <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_found) begin
        r_rr_ptr   <= (w_grant_idx == ID_W'(NUM_REQ-1)) ? '0 : w_grant_idx + ID_W'(1);
        r_wr_addr  <= w_sel_addr;
        r_wr_data  <= w_sel_data;
        r_grant_id <= w_grant_idx;
        // register 0 is hardwired; the write is consumed but not enabled
        r_wr_en    <= (w_sel_addr != '0);
      end else begin
        r_wr_en    <= 1'b0;
      end

      if (i_cnt_clear) begin
        r_cnt <= '0;
      end else if (w_contend && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign o_wr_en          = r_wr_en;
  assign o_wr_addr        = r_wr_addr;
  assign o_wr_data        = r_wr_data;
  assign o_grant_id       = r_grant_id;
  assign o_contention_cnt = r_cnt;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    grant_id;
  logic [CW-1:0] cnt;
  logic          cnt_clear;

  int n_tests = 0;
  int n_fail  = 0;

  rf_wb_arbiter #(.NUM_REQ(NR), .WIDTH_ADDR(AW), .WIDTH_DATA(DW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_data(req_data), .o_wr_en(wr_en), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .o_grant_id(grant_id), .o_contention_cnt(cnt), .i_cnt_clear(cnt_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 3'b111; cnt_clear = 1'b0;
    set_req(0, 5'd1, 32'h0000_0011);
    set_req(1, 5'd2, 32'h0000_0022);
    set_req(2, 5'd3, 32'h0000_0033);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL rst_ready: got %b want 000", req_ready); end
      n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
      n_tests++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", cnt); end
    end
    n_tests++; if (grant_id !== 2'd0 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin
      n_fail++; $display("FAIL rst_regs: got id %0d addr %0d data %h want 0 0 0", grant_id, wr_addr, wr_data); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rst_first_ready: got %b want 001", req_ready); end
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b1 || grant_id !== 2'd0 || wr_addr !== 5'd1) begin
      n_fail++; $display("FAIL rst_first_grant: got en %b id %0d addr %0d want 1 0 1", wr_en, grant_id, wr_addr); end
    n_tests++; if (cnt !== 4'd1) begin n_fail++; $display("FAIL rst_first_cnt: got %0d want 1", cnt); end
    @(negedge clk); req_valid = 3'b000; cnt_clear = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (cnt !== 4'd0 || wr_en !== 1'b0) begin
      n_fail++; $display("FAIL idle_clear: got cnt %0d en %b want 0 0", cnt, wr_en); end
    @(negedge clk); cnt_clear = 1'b0;
  endtask

  // pointer is 1 on entry
  task automatic test_single();
    req_valid = 3'b010; set_req(1, 5'd5, 32'hDEAD_BEEF); #1;
    n_tests++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready: got %b want 010", req_ready); end
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEAD_BEEF || grant_id !== 2'd1) begin
      n_fail++; $display("FAIL single_cmd: got en %b addr %0d data %h id %0d want 1 5 deadbeef 1", wr_en, wr_addr, wr_data, grant_id); end
    // pointer now 2: requester 0 alone must still win via wrap
    @(negedge clk); req_valid = 3'b001; set_req(0, 5'd7, 32'hA5A5_A5A5); #1;
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL single_wrap_ready: got %b want 001", req_ready); end
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || grant_id !== 2'd0) begin
      n_fail++; $display("FAIL single_wrap_cmd: got en %b addr %0d id %0d want 1 7 0", wr_en, wr_addr, grant_id); end
    @(negedge clk); req_valid = 3'b000; #1;
    n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL idle_ready: got %b want 000", req_ready); end
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b0 || wr_addr !== 5'd7 || wr_data !== 32'hA5A5_A5A5 || grant_id !== 2'd0) begin
      n_fail++; $display("FAIL idle_hold: got en %b addr %0d data %h id %0d want 0 7 a5a5a5a5 0", wr_en, wr_addr, wr_data, grant_id); end
    n_tests++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL single_cnt: got %0d want 0", cnt); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [2:0] exp_oh;
    // grant requester 2 alone to park the pointer at 0
    req_valid = 3'b100; set_req(2, 5'd3, 32'h1000_0002); cnt_clear = 1'b1;
    @(posedge clk); @(negedge clk);
    cnt_clear = 1'b0; req_valid = 3'b111;
    set_req(0, 5'd1, 32'h1000_0000);
    set_req(1, 5'd2, 32'h1000_0001);
    for (int k = 0; k < 6; k++) begin
      exp_oh = 3'b001 << (k % 3);
      #1;
      n_tests++; if (req_ready !== exp_oh) begin n_fail++; $display("FAIL cont_ready[%0d]: got %b want %b", k, req_ready, exp_oh); end
      @(posedge clk); #1;
      n_tests++; if (wr_en !== 1'b1 || grant_id !== 2'(k % 3) || wr_data !== (32'h1000_0000 + 32'(k % 3))) begin
        n_fail++; $display("FAIL cont_cmd[%0d]: got en %b id %0d data %h want 1 %0d %h", k, wr_en, grant_id, wr_data, k % 3, 32'h1000_0000 + 32'(k % 3)); end
      @(negedge clk);
    end
    n_tests++; if (cnt !== 4'd6) begin n_fail++; $display("FAIL cont_cnt: got %0d want 6", cnt); end
    req_valid = 3'b000;
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b0 || cnt !== 4'd6) begin
      n_fail++; $display("FAIL cont_idle: got en %b cnt %0d want 0 6", wr_en, cnt); end
    @(negedge clk);
  endtask

  // pointer is 0 on entry
  task automatic test_x0();
    req_valid = 3'b001; set_req(0, 5'd9, 32'h0000_0099);
    @(posedge clk); @(negedge clk);
    req_valid = 3'b100; set_req(2, 5'd0, 32'h1234_5678); #1;
    n_tests++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL x0_ready: got %b want 100", req_ready); end
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b0 || grant_id !== 2'd2 || wr_addr !== 5'd0 || wr_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL x0_cmd: got en %b id %0d addr %0d data %h want 0 2 0 12345678", wr_en, grant_id, wr_addr, wr_data); end
    // pointer must now be 0: with 0 and 2 requesting, 0 wins
    @(negedge clk); req_valid = 3'b101; set_req(2, 5'd4, 32'h0000_0044); #1;
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL x0_ptr: got %b want 001", req_ready); end
    @(posedge clk); @(negedge clk);
    req_valid = 3'b000;
    @(posedge clk); @(negedge clk);
  endtask

  // pointer is 1 on entry
  task automatic test_saturation();
    cnt_clear = 1'b1;
    @(posedge clk); @(negedge clk);
    cnt_clear = 1'b0; req_valid = 3'b011;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 14) begin
        n_tests++; if (cnt !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d want 15", cnt); end
      end
      @(negedge clk);
    end
    n_tests++; if (cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d want 15", cnt); end
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clear: got %0d want 0", cnt); end
    @(negedge clk); cnt_clear = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (cnt !== 4'd1) begin n_fail++; $display("FAIL sat_restart: got %0d want 1", cnt); end
    @(negedge clk); req_valid = 3'b000;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    // park pointer at 2 so the post-reset grant to 0 is meaningful
    req_valid = 3'b010;
    @(posedge clk); @(negedge clk);
    req_valid = 3'b111;
    @(posedge clk); @(negedge clk);
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b1 || grant_id !== 2'd0) begin
      n_fail++; $display("FAIL mid_second: got en %b id %0d want 1 0", wr_en, grant_id); end
    @(negedge clk); rst_n = 1'b0; #1;
    n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL mid_ready: got %b want 000", req_ready); end
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b0 || wr_data !== 32'd0 || grant_id !== 2'd0 || cnt !== 4'd0) begin
      n_fail++; $display("FAIL mid_reset: got en %b data %h id %0d cnt %0d want 0 0 0 0", wr_en, wr_data, grant_id, cnt); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL mid_first_ready: got %b want 001", req_ready); end
    @(posedge clk); #1;
    n_tests++; if (wr_en !== 1'b1 || grant_id !== 2'd0) begin
      n_fail++; $display("FAIL mid_first_grant: got en %b id %0d want 1 0", wr_en, grant_id); end
    @(negedge clk); req_valid = 3'b000;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; cnt_clear = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_saturation();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
